// File: rtl/gambling_pkg.sv
// Shared definitions for the slot-machine CPU: opcodes, instruction fields,
// memory map, PS/2 key codes and an instruction encoder used to build the ROM.
package gambling_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_ADDI = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_BEQ  = 4'd7,
        OP_BNE  = 4'd8,
        OP_BLT  = 4'd9,
        OP_J    = 4'd10,
        OP_RND  = 4'd11
    } op_e;

    localparam int OP_LSB = 28;
    localparam int RD_LSB = 24;
    localparam int RS_LSB = 20;
    localparam int RT_LSB = 16;
    localparam int NUM_REGS = 16;

    localparam int ADDR_KEY    = 10;
    localparam int ADDR_MONEY  = 20;
    localparam int ADDR_SYM_A  = 24;
    localparam int ADDR_SYM_B  = 28;
    localparam int ADDR_SYM_C  = 32;
    localparam int ADDR_RESULT = 36;

    localparam int KEY_UP    = 'h75;
    localparam int KEY_DOWN  = 'h72;
    localparam int KEY_ENTER = 'h5A;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [31:0] enc(op_e op, int rd, int rs, int rt, int imm);
        logic [31:0] w;
        w = '0;
        w[OP_LSB +: 4] = op;
        w[RD_LSB +: 4] = rd[3:0];
        w[RS_LSB +: 4] = rs[3:0];
        w[RT_LSB +: 4] = rt[3:0];
        w[15:0]        = imm[15:0];
        return w;
    endfunction

    // Branch offset so that the target is reached from PC+1.
    function automatic int rel(int pc, int target);
        return target - pc - 1;
    endfunction

endpackage

// File: rtl/gambling_tec_if.sv
// Data-memory bus between the CPU core and its RAM: combinational read, clocked write.
interface gambling_tec_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/gambling_tec_data_memory.sv
// Word-addressed data RAM; out-of-range addresses read 0 and swallow writes.
module data_memory #(
    parameter int RAM_WORDS = 64
) (
    input  logic           clk,
    input  logic           rst,
    gambling_tec_if.slave  bus
);
    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   RAM [0:RAM_WORDS-1];
    logic          in_range;
    logic [AW-1:0] idx;

    always_comb begin
        in_range  = bus.addr < 32'(RAM_WORDS);
        idx       = bus.addr[AW-1:0];
        bus.rdata = in_range ? RAM[idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_WORDS; i++) RAM[i] <= '0;
        end else if (bus.we && in_range) begin
            RAM[idx] <= bus.wdata;
        end
    end

endmodule

// File: rtl/gambling_tec.sv
// Single-cycle 32-bit CPU running a fixed slot-machine program; all I/O is
// through data memory (key code in, money/symbols/result out).
module gambling_tec
    import gambling_pkg::*;
#(
    parameter int RAM_WORDS = 64,
    parameter int ROM_WORDS = 64
) (
    input logic clk,
    input logic rst
);
    // Program labels. Registers: r2 previous key, r3 key, r5 money, r6 = 10,
    // r7/r9/r10 symbols, r8 = 7, r11 result, r12..r14 key codes.
    localparam int L_POLL  = 7;
    localparam int L_UP    = 16;
    localparam int L_DOWN  = 19;
    localparam int L_ENTER = 23;
    localparam int L_NOTAB = 39;
    localparam int L_PAIR  = 43;
    localparam int L_STORE = 45;

    gambling_tec_if mem_bus ();

    data_memory #(.RAM_WORDS(RAM_WORDS)) data_mem (
        .clk (clk),
        .rst (rst),
        .bus (mem_bus)
    );

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    logic [15:0] lfsr_q, lfsr_d;

    logic [31:0] rom_data, instr;
    op_e         op;
    logic [3:0]  rd, rs, rt;
    logic [31:0] imm_sext, rd_val, rs_val, rt_val;
    logic        reg_we;
    logic [31:0] reg_wdata;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we;

    always_comb begin
        rom_data = enc(OP_NOP, 0, 0, 0, 0);
        case (pc_q)
            0:  rom_data = enc(OP_ADDI, 1, 0, 0, 100);
            1:  rom_data = enc(OP_SW,   1, 0, 0, ADDR_MONEY);
            2:  rom_data = enc(OP_ADDI, 6, 0, 0, 10);
            3:  rom_data = enc(OP_ADDI, 8, 0, 0, 7);
            4:  rom_data = enc(OP_ADDI, 12, 0, 0, KEY_UP);
            5:  rom_data = enc(OP_ADDI, 13, 0, 0, KEY_DOWN);
            6:  rom_data = enc(OP_ADDI, 14, 0, 0, KEY_ENTER);
            7:  rom_data = enc(OP_LW,   3, 0, 0, ADDR_KEY);
            8:  rom_data = enc(OP_BEQ,  0, 3, 2, rel(8, L_POLL));
            9:  rom_data = enc(OP_ADD,  2, 3, 0, 0);
            10: rom_data = enc(OP_BEQ,  0, 3, 0, rel(10, L_POLL));
            11: rom_data = enc(OP_LW,   5, 0, 0, ADDR_MONEY);
            12: rom_data = enc(OP_BEQ,  0, 3, 14, rel(12, L_ENTER));
            13: rom_data = enc(OP_BEQ,  0, 3, 12, rel(13, L_UP));
            14: rom_data = enc(OP_BEQ,  0, 3, 13, rel(14, L_DOWN));
            15: rom_data = enc(OP_J,    0, 0, 0, L_POLL);
            16: rom_data = enc(OP_ADDI, 5, 5, 0, 10);
            17: rom_data = enc(OP_SW,   5, 0, 0, ADDR_MONEY);
            18: rom_data = enc(OP_J,    0, 0, 0, L_POLL);
            19: rom_data = enc(OP_BLT,  0, 5, 6, rel(19, L_POLL));
            20: rom_data = enc(OP_ADDI, 5, 5, 0, -10);
            21: rom_data = enc(OP_SW,   5, 0, 0, ADDR_MONEY);
            22: rom_data = enc(OP_J,    0, 0, 0, L_POLL);
            23: rom_data = enc(OP_BLT,  0, 5, 6, rel(23, L_POLL));
            24: rom_data = enc(OP_ADDI, 5, 5, 0, -10);
            25: rom_data = enc(OP_RND,  7, 0, 0, 0);
            26: rom_data = enc(OP_AND,  7, 7, 8, 0);
            27: rom_data = enc(OP_RND,  9, 0, 0, 0);
            28: rom_data = enc(OP_AND,  9, 9, 8, 0);
            29: rom_data = enc(OP_RND,  10, 0, 0, 0);
            30: rom_data = enc(OP_AND,  10, 10, 8, 0);
            31: rom_data = enc(OP_SW,   7, 0, 0, ADDR_SYM_A);
            32: rom_data = enc(OP_SW,   9, 0, 0, ADDR_SYM_B);
            33: rom_data = enc(OP_SW,   10, 0, 0, ADDR_SYM_C);
            34: rom_data = enc(OP_BNE,  0, 7, 9, rel(34, L_NOTAB));
            35: rom_data = enc(OP_BNE,  0, 9, 10, rel(35, L_PAIR));
            36: rom_data = enc(OP_ADDI, 11, 0, 0, 1);
            37: rom_data = enc(OP_ADDI, 5, 5, 0, 100);
            38: rom_data = enc(OP_J,    0, 0, 0, L_STORE);
            39: rom_data = enc(OP_BEQ,  0, 7, 10, rel(39, L_PAIR));
            40: rom_data = enc(OP_BEQ,  0, 9, 10, rel(40, L_PAIR));
            41: rom_data = enc(OP_ADDI, 11, 0, 0, 0);
            42: rom_data = enc(OP_J,    0, 0, 0, L_STORE);
            43: rom_data = enc(OP_ADDI, 11, 0, 0, 2);
            44: rom_data = enc(OP_ADDI, 5, 5, 0, 20);
            45: rom_data = enc(OP_SW,   5, 0, 0, ADDR_MONEY);
            46: rom_data = enc(OP_SW,   11, 0, 0, ADDR_RESULT);
            47: rom_data = enc(OP_J,    0, 0, 0, L_POLL);
            default: rom_data = enc(OP_NOP, 0, 0, 0, 0);
        endcase
        instr = (pc_q < 32'(ROM_WORDS)) ? rom_data : '0;
    end

    always_comb begin
        op       = op_e'(instr[OP_LSB +: 4]);
        rd       = instr[RD_LSB +: 4];
        rs       = instr[RS_LSB +: 4];
        rt       = instr[RT_LSB +: 4];
        imm_sext = {{16{instr[15]}}, instr[15:0]};
        rd_val   = regs_q[rd];
        rs_val   = regs_q[rs];
        rt_val   = regs_q[rt];
    end

    always_comb begin
        pc_d      = pc_q + 32'd1;
        regs_d    = regs_q;
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        reg_we    = 1'b0;
        reg_wdata = '0;
        mem_addr  = rs_val + imm_sext;
        mem_wdata = rd_val;
        mem_we    = 1'b0;
        case (op)
            OP_ADD:  begin reg_we = 1'b1; reg_wdata = rs_val + rt_val; end
            OP_SUB:  begin reg_we = 1'b1; reg_wdata = rs_val - rt_val; end
            OP_AND:  begin reg_we = 1'b1; reg_wdata = rs_val & rt_val; end
            OP_ADDI: begin reg_we = 1'b1; reg_wdata = rs_val + imm_sext; end
            OP_LW:   begin reg_we = 1'b1; reg_wdata = mem_bus.rdata; end
            OP_SW:   mem_we = 1'b1;
            OP_BEQ:  if (rs_val == rt_val) pc_d = pc_q + 32'd1 + imm_sext;
            OP_BNE:  if (rs_val != rt_val) pc_d = pc_q + 32'd1 + imm_sext;
            OP_BLT:  if ($signed(rs_val) < $signed(rt_val)) pc_d = pc_q + 32'd1 + imm_sext;
            OP_J:    pc_d = imm_sext;
            OP_RND:  begin reg_we = 1'b1; reg_wdata = {16'd0, lfsr_q}; end
            default: ;
        endcase
        if (reg_we && rd != 4'd0) regs_d[rd] = reg_wdata;
    end

    assign mem_bus.addr  = mem_addr;
    assign mem_bus.wdata = mem_wdata;
    assign mem_bus.we    = mem_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= '0;
            regs_q <= '{default: '0};
            lfsr_q <= LFSR_SEED;
        end else begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: tb/tb_gambling_tec.sv
// Self-checking bench for gambling_tec: drives key codes into RAM[10] and
// checks money/symbols/result against a behavioural slot-machine model.
module tb_gambling_tec;

    localparam int A_KEY = 10, A_MONEY = 20, A_SA = 24, A_SB = 28, A_SC = 32, A_RES = 36;
    localparam logic [31:0] K_UP = 32'h75, K_DOWN = 32'h72, K_ENTER = 32'h5A;

    typedef struct {
        logic [31:0] key;
        int          exp_money;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    gambling_tec #(.RAM_WORDS(64), .ROM_WORDS(64)) dut (
        .clk (clk),
        .rst (rst)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] peek(int a);
        return dut.data_mem.RAM[a];
    endfunction

    task automatic set_key(logic [31:0] k);
        dut.data_mem.RAM[A_KEY] = k;
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic press(logic [31:0] k, int hold, int gap);
        set_key(k);
        tick(hold);
        set_key(32'd0);
        tick(gap);
    endtask

    // Scoring rule of a spin, from the symbol values alone.
    function automatic void score(int a, int b, int c, output int res, output int bonus);
        if (a == b && b == c) begin
            res = 1; bonus = 100;
        end else if (a == b || b == c || a == c) begin
            res = 2; bonus = 20;
        end else begin
            res = 0; bonus = 0;
        end
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[16];
        logic [31:0] pool[6];
        int          money, prev, res, bonus, exp_res, nz;
        int          sa, sb, sc;
        logic [31:0] k;

        tbl[0] = '{K_UP, 110};
        tbl[1] = '{32'h1C, 110};
        tbl[2] = '{K_DOWN, 100};
        tbl[3] = '{32'h74, 100};
        tbl[4] = '{32'h6B, 100};
        for (int i = 0; i < 11; i++) tbl[5 + i] = '{K_DOWN, (i < 10) ? 90 - 10 * i : 0};
        pool = '{K_UP, K_DOWN, K_ENTER, 32'h1C, 32'h6B, 32'h0};

        // Power-up: money initialised, outputs clear.
        do_reset();
        tick(30);
        check("reset_money", peek(A_MONEY), 100);
        check("reset_sym_a", peek(A_SA), 0);
        check("reset_sym_b", peek(A_SB), 0);
        check("reset_sym_c", peek(A_SC), 0);
        check("reset_result", peek(A_RES), 0);

        press(K_UP, 10, 20);
        check("up_once_money", peek(A_MONEY), 110);
        check("up_once_sym_a", peek(A_SA), 0);
        check("up_once_sym_b", peek(A_SB), 0);
        check("up_once_sym_c", peek(A_SC), 0);
        check("up_once_result", peek(A_RES), 0);
        press(K_UP, 10, 25);
        press(K_UP, 10, 25);
        check("up_three_money", peek(A_MONEY), 130);

        do_reset();
        tick(30);
        press(K_UP, 50, 25);
        check("up_held_money", peek(A_MONEY), 110);

        // Table of single presses from a fresh 100, ending with DOWN at zero.
        do_reset();
        tick(30);
        for (int i = 0; i < 16; i++) begin
            press(tbl[i].key, 10, 25);
            check($sformatf("tbl%0d_money", i), peek(A_MONEY), 32'(tbl[i].exp_money));
            check($sformatf("tbl%0d_result", i), peek(A_RES), 0);
        end

        press(K_ENTER, 10, 30);
        check("broke_enter_money", peek(A_MONEY), 0);
        check("broke_enter_sym_a", peek(A_SA), 0);
        check("broke_enter_sym_b", peek(A_SB), 0);
        check("broke_enter_sym_c", peek(A_SC), 0);
        check("broke_enter_result", peek(A_RES), 0);

        // First spin from 100.
        do_reset();
        tick(30);
        press(K_ENTER, 10, 30);
        sa = int'(peek(A_SA)); sb = int'(peek(A_SB)); sc = int'(peek(A_SC));
        check("spin_sym_a_range", 32'(sa <= 7), 1);
        check("spin_sym_b_range", 32'(sb <= 7), 1);
        check("spin_sym_c_range", 32'(sc <= 7), 1);
        score(sa, sb, sc, res, bonus);
        check("spin_result", peek(A_RES), 32'(res));
        check("spin_money", peek(A_MONEY), 32'(90 + bonus));

        // Random key sequence; each key held 30 cycles, which also bounds action latency.
        money   = 90 + bonus;
        exp_res = res;
        prev    = 0;
        for (int it = 0; it < 60; it++) begin
            logic spun;
            spun = 1'b0;
            k = pool[$urandom_range(0, 5)];
            set_key(k);
            tick(30);
            if (int'(k) != prev && k != 32'd0) begin
                if (k == K_UP) money += 10;
                else if (k == K_DOWN && money >= 10) money -= 10;
                else if (k == K_ENTER && money >= 10) begin
                    spun = 1'b1;
                    sa = int'(peek(A_SA)); sb = int'(peek(A_SB)); sc = int'(peek(A_SC));
                    check($sformatf("rnd%0d_sym_range", it), 32'(sa <= 7 && sb <= 7 && sc <= 7), 1);
                    score(sa, sb, sc, exp_res, bonus);
                    money = money - 10 + bonus;
                end
            end
            prev = int'(k);
            check($sformatf("rnd%0d_money", it), peek(A_MONEY), 32'(money));
            check($sformatf("rnd%0d_result", it), peek(A_RES), 32'(exp_res));
            if (!spun) begin
                check($sformatf("rnd%0d_sym_a_hold", it), peek(A_SA), 32'(sa));
                check($sformatf("rnd%0d_sym_c_hold", it), peek(A_SC), 32'(sc));
            end
        end

        // Reset in the middle of a spin wipes everything, then the program restarts.
        do_reset();
        tick(30);
        set_key(K_ENTER);
        tick(12);
        rst = 1'b1;
        tick(2);
        nz = 0;
        for (int a = 0; a < 64; a++) if (peek(a) != 32'd0) nz++;
        check("midspin_reset_nonzero_words", 32'(nz), 0);
        rst = 1'b0;
        tick(30);
        check("after_reset_money", peek(A_MONEY), 100);
        check("after_reset_result", peek(A_RES), 0);
        check("after_reset_sym_a", peek(A_SA), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gambling_tec.md
GAMBLING_TEC -- requirements
Module: gambling_tec

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 64, number of 32-bit data-memory entries.
REQ-002 SHALL have parameter ROM_WORDS, default 64, number of 32-bit instruction words.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-005 SHALL have no other ports; all I/O is memory-mapped in data memory.
REQ-006 SHALL contain a data-memory instance named data_mem holding array RAM[0:RAM_WORDS-1] of 32-bit words.
REQ-007 SHALL index RAM directly by effective address: word address N is RAM[N].
REQ-008 SHALL use this map: 10 = key code (written externally, PS/2 set-2 code), 20 = money, 24/28/32 = symbols A/B/C, 36 = result.

Function
REQ-009 SHALL be a single-cycle 32-bit CPU: combinational ROM read, combinational RAM read, RAM write at clk edge, PC += 1 per instruction.
REQ-010 SHALL have 16 x 32-bit registers; r0 reads zero and ignores writes.
REQ-011 SHALL encode instructions as op[31:28], rd[27:24], rs[23:20], rt[19:16], imm[15:0] sign-extended.
REQ-012 SHALL support ops ADD, SUB, AND, ADDI, LW (rd = RAM[rs+imm]), SW (RAM[rs+imm] = rd), BEQ, BNE, BLT (signed, target PC+1+imm), J (PC = imm), RND (rd = LFSR value).
REQ-013 SHALL provide a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1) that advances every clock.
REQ-014 SHALL treat unused opcodes as NOP; arithmetic wraps modulo 2^32.
REQ-015 SHALL ignore stores to addresses >= RAM_WORDS and read 0 from them.
REQ-016 SHALL never write address 10 from the program; it is externally driven.
REQ-017 SHALL hold a fixed ROM program that first stores 100 to money, then loops polling address 10.
REQ-018 SHALL have a poll loop of at most 8 cycles per iteration.
REQ-019 SHALL act only on a press edge: the key value differs from the previous poll and is nonzero; holding a key acts once.
REQ-020 SHALL, on key 0x75 (UP), add 10 to money.
REQ-021 SHALL, on key 0x72 (DOWN), subtract 10 from money if money >= 10, else leave money unchanged.
REQ-022 SHALL, on key 0x5A (ENTER) with money >= 10, run a spin: money -= 10; A, B, C = three successive RND values & 7.
REQ-023 SHALL score a spin as result 1 and money += 100 if A==B==C; result 2 and money += 20 if exactly two are equal; else result 0.
REQ-024 SHALL ignore ENTER when money < 10 and leave symbols and result unchanged.
REQ-025 SHALL ignore all other key codes.
REQ-026 SHALL complete any action within 30 cycles of the press edge.

Reset
REQ-027 SHALL, while rst is high, set PC = 0, all registers = 0, all RAM words = 0, and the LFSR to its seed.
REQ-028 SHALL restart the program from PC 0 after reset deasserts; reset mid-spin discards partial results.

Structure
REQ-029 SHALL place opcode enum, field positions, memory-map addresses and key-code constants in shared package gambling_pkg.
REQ-030 SHALL implement data memory as sub-module data_memory, instantiated as data_mem; ROM, register file and datapath stay in the top.

Verification
REQ-031 SHALL pass: reset 2 cycles, idle 30 cycles -> RAM[20]=100, RAM[24..36]=0.
REQ-032 SHALL pass: RAM[10]=0x75 for 10 cycles, then 0, wait 20 -> RAM[20]=110, RAM[24]=RAM[28]=RAM[32]=RAM[36]=0.
REQ-033 SHALL pass: three separate UP presses -> 130; UP held 50 cycles -> 110.
REQ-034 SHALL pass: DOWN pressed 11 times from 100 -> RAM[20]=0; last press no change.
REQ-035 SHALL pass: ENTER from 100 -> symbols each 0..7; result consistent with REQ-023; money equals 90, 110 or 190 accordingly.
REQ-036 SHALL pass: ENTER with money 0 -> RAM[20..36] unchanged; reset asserted mid-spin -> all RAM 0, then money 100.
